memoria_datos_param: RTL

MEMORIA_DATOS_PARAM -- requirements
Module: memoria_datos_param

---
 rtl/memoria_datos_param.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/memoria_datos_param.sv
// Parameterised data memory: byte/half/word access, registered reads, write-first
// on same-word read/write, misalignment rejection and a full-array clear sequencer.
module memoria_datos_param #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EscrMem,
  input  logic              LeerMem,
  input  logic [ADDR_W-1:0] Direc,
  input  logic [DATA_W-1:0] Datain,
  input  logic [1:0]        Tam,
  input  logic              ConSigno,
  input  logic              Limpiar,
  output logic [DATA_W-1:0] Dataout,
  output logic              Valido,
  output logic              Error,
  output logic              Ocupado
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]        state, state_next;
  logic [IDX_W-1:0]  clr_cnt, clr_cnt_next;
  logic [DATA_W-1:0] dataout_next;
  logic              valido_next;
  logic              error_next;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_wdata;

  logic [OFF_W-1:0]  offset;
  logic [IDX_W-1:0]  word_idx;
  logic              misaligned;
  logic [NB-1:0]     byte_en;
  logic [DATA_W-1:0] bit_mask;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] lane_data;
  logic [DATA_W-1:0] merged_word;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] read_ext;

  // Address bits above the word index alias onto the same words.
  assign offset   = Direc[OFF_W-1:0];
  assign word_idx = Direc[OFF_W +: IDX_W];

  generate
    if (ADDR_W > OFF_W + IDX_W) begin : g_alias
      logic unused_hi;
      assign unused_hi = ^Direc[ADDR_W-1:OFF_W+IDX_W];
    end
  endgenerate

  always_comb begin
    misaligned = 1'b0;
    case (Tam)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = Direc[0];
      2'b10:   misaligned = |offset;
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    byte_en = '1;
    case (Tam)
      2'b00:   byte_en = NB'(1) << offset;
      2'b01:   byte_en = NB'(3) << offset;
      default: byte_en = '1;
    endcase
  end

  always_comb begin
    bit_mask = '0;
    for (int b = 0; b < NB; b++) begin
      bit_mask[b*8 +: 8] = {8{byte_en[b]}};
    end
  end

  // Merged word feeds both the write port and the read path (write-first).
  assign old_word    = mem[word_idx];
  assign lane_data   = Datain << {offset, 3'b000};
  assign merged_word = EscrMem ? ((old_word & ~bit_mask) | (lane_data & bit_mask))
                               : old_word;
  assign shifted     = merged_word >> {offset, 3'b000};

  always_comb begin
    read_ext = shifted;
    case (Tam)
      2'b00:   read_ext = {{(DATA_W-8){ConSigno & shifted[7]}}, shifted[7:0]};
      2'b01:   read_ext = {{(DATA_W-16){ConSigno & shifted[15]}}, shifted[15:0]};
      default: read_ext = shifted;
    endcase
  end

  // Next-state, memory-port and output decode.
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    dataout_next = Dataout;
    valido_next  = 1'b0;
    error_next   = 1'b0;
    mem_we       = 1'b0;
    mem_idx      = word_idx;
    mem_wdata    = merged_word;
    case (state)
      ST_IDLE: begin
        if (Limpiar) begin
          state_next   = ST_CLEAR;
          clr_cnt_next = '0;
        end else if (EscrMem || LeerMem) begin
          if (misaligned) begin
            error_next = 1'b1;
          end else begin
            mem_we = EscrMem;
            if (LeerMem) begin
              valido_next  = 1'b1;
              dataout_next = read_ext;
            end
          end
        end
      end
      ST_CLEAR: begin
        mem_we       = 1'b1;
        mem_idx      = clr_cnt;
        mem_wdata    = '0;
        clr_cnt_next = clr_cnt + IDX_W'(1);
        if (clr_cnt == IDX_W'(DEPTH - 1)) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      clr_cnt <= '0;
      Dataout <= '0;
      Valido  <= 1'b0;
      Error   <= 1'b0;
      Ocupado <= 1'b0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
      Dataout <= dataout_next;
      Valido  <= valido_next;
      Error   <= error_next;
      Ocupado <= (state_next == ST_CLEAR);
    end
  end

  // Array contents survive reset; reset only blocks the write on its own edge.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_idx] <= mem_wdata;
    end
  end

endmodule
